// File: rtl/iob_plic_unit_if.sv
// IOb native bus bundle between a bus master and the PLIC register slave.
interface iob_plic_unit_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic              iob_avalid;
  logic [ADDR_W-1:0] iob_addr;
  logic [DATA_W-1:0] iob_wdata;
  logic [DATA_W/8-1:0] iob_wstrb;
  logic              iob_rvalid;
  logic [DATA_W-1:0] iob_rdata;
  logic              iob_ready;

  modport master (
    output iob_avalid, iob_addr, iob_wdata, iob_wstrb,
    input  iob_rvalid, iob_rdata, iob_ready
  );

  modport slave (
    input  iob_avalid, iob_addr, iob_wdata, iob_wstrb,
    output iob_rvalid, iob_rdata, iob_ready
  );
endinterface

// File: rtl/iob_plic_unit.sv
// PLIC on the IOb bus: level/edge gateways, per-target priority arbitration, claim/complete.
// Define IOB_PLIC_IRQ_REG_EN to register the irq outputs (one extra cycle of latency).
module iob_plic_unit #(
  parameter int ADDR_W            = 16,
  parameter int DATA_W            = 32,
  parameter int N_SOURCES         = 8,
  parameter int N_TARGETS         = 2,
  parameter int PRIORITIES        = 8,
  parameter int MAX_PENDING_COUNT = 8,
  parameter int HAS_THRESHOLD     = 1,
  parameter int HAS_CONFIG_REG    = 1
) (
  input  logic                 clk_i,
  input  logic                 cke_i,
  input  logic                 rst_n_i,
  iob_plic_unit_if.slave       bus,
  input  logic [N_SOURCES-1:0] src,
  output logic [N_TARGETS-1:0] irq
);
  localparam int PW = (PRIORITIES > 1) ? $clog2(PRIORITIES) : 1;
  localparam int CW = $clog2(MAX_PENDING_COUNT + 1);
  localparam int IW = $clog2(N_SOURCES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_PENDING_COUNT);
  localparam logic [31:0] CFG = {7'd0, 1'(HAS_THRESHOLD != 0), 8'(PRIORITIES),
                                 8'(N_TARGETS), 8'(N_SOURCES)};

  function automatic logic [DATA_W-1:0] f_merge(input logic [DATA_W-1:0] old,
                                                input logic [DATA_W-1:0] wd,
                                                input logic [DATA_W-1:0] m);
    return (old & ~m) | (wd & m);
  endfunction

  logic [N_SOURCES-1:0] r_el, r_pend, r_insvc, r_src_q;
  logic [CW-1:0]        r_cnt  [N_SOURCES];
  logic [PW-1:0]        r_prio [N_SOURCES];
  logic [N_SOURCES-1:0] r_ie   [N_TARGETS];
  logic [PW-1:0]        r_th   [N_TARGETS];
  logic                 r_rvalid;
  logic [DATA_W-1:0]    r_rdata;

  logic [ADDR_W-1:0]    w_addr_full;
  logic                 w_unused_addr;
  logic [11:0]          w_addr;
  logic                 w_wr, w_rd;
  logic [DATA_W-1:0]    w_mask, w_cmpl_val, w_rdata, w_el_merged;
  logic [N_SOURCES-1:0] w_el_new, w_el_chg, w_ip, w_edge, w_claim_vec, w_cmpl_vec;
  logic [PW-1:0]        w_th   [N_TARGETS];
  logic [IW-1:0]        w_win  [N_TARGETS];
  logic [N_TARGETS-1:0] w_irq;
  logic [IW-1:0]        w_claim_id;
  logic                 w_cmpl_hit;

  assign w_addr_full   = bus.iob_addr;
  assign w_unused_addr = ^w_addr_full[ADDR_W-1:12];
  assign w_addr        = w_addr_full[11:0];
  assign w_wr          = bus.iob_avalid & (|bus.iob_wstrb);
  assign w_rd          = bus.iob_avalid & ~(|bus.iob_wstrb);
  assign w_edge        = src & ~r_src_q;
  assign w_cmpl_val    = bus.iob_wdata & w_mask;
  assign w_el_merged   = f_merge(DATA_W'(r_el), bus.iob_wdata, w_mask);
  assign w_el_new      = w_el_merged[N_SOURCES-1:0];
  assign w_el_chg      = (w_wr && w_addr == 12'h004) ? (w_el_new ^ r_el) : '0;

  assign bus.iob_ready  = 1'b1;
  assign bus.iob_rvalid = r_rvalid;
  assign bus.iob_rdata  = r_rdata;

  always_comb begin
    for (int b = 0; b < DATA_W/8; b++) w_mask[8*b +: 8] = {8{bus.iob_wstrb[b]}};
  end

  always_comb begin
    for (int i = 0; i < N_SOURCES; i++)
      w_ip[i] = r_el[i] ? (r_cnt[i] != '0) : r_pend[i];
    for (int t = 0; t < N_TARGETS; t++)
      w_th[t] = (HAS_THRESHOLD != 0) ? r_th[t] : '0;
  end

  // Strict '>' against a running best seeded with the threshold gives both the
  // threshold test and lowest-ID tie breaking.
  always_comb begin
    logic [PW-1:0] bp;
    logic [IW-1:0] bid;
    bp  = '0;
    bid = '0;
    for (int t = 0; t < N_TARGETS; t++) begin
      bp  = w_th[t];
      bid = '0;
      for (int i = 0; i < N_SOURCES; i++)
        if (w_ip[i] && r_ie[t][i] && !r_insvc[i] && r_prio[i] > bp) begin
          bp  = r_prio[i];
          bid = IW'(i + 1);
        end
      w_win[t] = bid;
      w_irq[t] = (bid != '0);
    end
  end

  always_comb begin
    w_rdata    = '0;
    w_claim_id = '0;
    w_cmpl_hit = 1'b0;
    if (w_addr == 12'h000 && HAS_CONFIG_REG != 0) w_rdata = CFG;
    if (w_addr == 12'h004) w_rdata = DATA_W'(r_el);
    if (w_addr == 12'h008) w_rdata = DATA_W'(w_ip);
    for (int i = 0; i < N_SOURCES; i++)
      if (w_addr == 12'h040 + 12'(4 * i)) w_rdata = DATA_W'(r_prio[i]);
    for (int t = 0; t < N_TARGETS; t++) begin
      if (w_addr == 12'h100 + 12'(16 * t)) w_rdata = DATA_W'(r_ie[t]);
      if (w_addr == 12'h104 + 12'(16 * t)) w_rdata = DATA_W'(w_th[t]);
      if (w_addr == 12'h108 + 12'(16 * t)) begin
        w_rdata = DATA_W'(w_win[t]);
        if (w_rd) w_claim_id = w_win[t];
        if (w_wr) w_cmpl_hit = 1'b1;
      end
    end
    for (int i = 0; i < N_SOURCES; i++) begin
      w_claim_vec[i] = (w_claim_id == IW'(i + 1));
      w_cmpl_vec[i]  = w_cmpl_hit && (w_cmpl_val == DATA_W'(i + 1));
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_el <= '0; r_pend <= '0; r_insvc <= '0; r_src_q <= '0;
      r_rvalid <= 1'b0; r_rdata <= '0;
      for (int i = 0; i < N_SOURCES; i++) begin r_cnt[i] <= '0; r_prio[i] <= '0; end
      for (int t = 0; t < N_TARGETS; t++) begin r_ie[t] <= '0; r_th[t] <= '0; end
    end else if (cke_i) begin
      r_src_q  <= src;
      r_rvalid <= w_rd;
      if (w_rd) r_rdata <= w_rdata;
      for (int i = 0; i < N_SOURCES; i++) begin
        if (w_el_chg[i]) begin
          r_cnt[i]  <= '0;
          r_pend[i] <= 1'b0;
        end else if (r_el[i]) begin
          if (w_edge[i] && !w_claim_vec[i])
            r_cnt[i] <= (r_cnt[i] == CNT_MAX) ? r_cnt[i] : r_cnt[i] + 1'b1;
          else if (!w_edge[i] && w_claim_vec[i])
            r_cnt[i] <= r_cnt[i] - 1'b1;
        end else begin
          if (w_claim_vec[i]) r_pend[i] <= 1'b0;
          else if (r_src_q[i] && !r_pend[i] && !r_insvc[i]) r_pend[i] <= 1'b1;
        end
        if (w_claim_vec[i])     r_insvc[i] <= 1'b1;
        else if (w_cmpl_vec[i]) r_insvc[i] <= 1'b0;
        if (w_wr && w_addr == 12'h040 + 12'(4 * i))
          r_prio[i] <= PW'(f_merge(DATA_W'(r_prio[i]), bus.iob_wdata, w_mask));
      end
      if (w_wr && w_addr == 12'h004) r_el <= w_el_new;
      for (int t = 0; t < N_TARGETS; t++) begin
        if (w_wr && w_addr == 12'h100 + 12'(16 * t))
          r_ie[t] <= N_SOURCES'(f_merge(DATA_W'(r_ie[t]), bus.iob_wdata, w_mask));
        if (HAS_THRESHOLD != 0 && w_wr && w_addr == 12'h104 + 12'(16 * t))
          r_th[t] <= PW'(f_merge(DATA_W'(r_th[t]), bus.iob_wdata, w_mask));
      end
    end
  end

`ifdef IOB_PLIC_IRQ_REG_EN
  logic [N_TARGETS-1:0] r_irq;
  always_ff @(posedge clk_i) begin
    if (!rst_n_i)   r_irq <= '0;
    else if (cke_i) r_irq <= w_irq;
  end
  assign irq = r_irq;
`else
  assign irq = w_irq;
`endif
endmodule

// File: tb/tb_iob_plic_unit.sv
// Directed bench for iob_plic_unit: register map, gateways, arbitration, claim/complete.
module tb_iob_plic_unit;
  logic       clk_i = 1'b0;
  logic       cke_i = 1'b1;
  logic       rst_n_i = 1'b0;
  logic [7:0] src = '0;
  logic [1:0] irq;
  logic [31:0] rdv;
  int n_vec = 0;
  int n_err = 0;

  iob_plic_unit_if #(.ADDR_W(16), .DATA_W(32)) bus ();

  iob_plic_unit dut (
    .clk_i  (clk_i),
    .cke_i  (cke_i),
    .rst_n_i(rst_n_i),
    .bus    (bus),
    .src    (src),
    .irq    (irq)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic wr_s(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s);
    @(negedge clk_i);
    bus.iob_avalid = 1'b1; bus.iob_addr = a; bus.iob_wdata = d; bus.iob_wstrb = s;
    @(negedge clk_i);
    bus.iob_avalid = 1'b0; bus.iob_wstrb = 4'h0;
  endtask

  task automatic wr(input logic [15:0] a, input logic [31:0] d);
    wr_s(a, d, 4'hF);
  endtask

  task automatic rd(input logic [15:0] a, output logic [31:0] d);
    @(negedge clk_i);
    bus.iob_avalid = 1'b1; bus.iob_addr = a; bus.iob_wstrb = 4'h0;
    @(negedge clk_i);
    bus.iob_avalid = 1'b0;
    d = bus.iob_rdata;
    if (cke_i && !bus.iob_rvalid) begin
      n_vec++; n_err++;
      $display("FAIL rvalid: got 0 expected 1 (addr 0x%04h)", a);
    end
  endtask

  task automatic rdchk(input string tag, input logic [15:0] a, input logic [31:0] exp);
    logic [31:0] v;
    rd(a, v);
    chk(tag, v, exp);
  endtask

  initial begin
    bus.iob_avalid = 1'b0; bus.iob_addr = '0; bus.iob_wdata = '0; bus.iob_wstrb = '0;
    cyc(3);
    rst_n_i = 1'b1;
    chk("rst_irq", {30'd0, irq}, 32'h0);
    chk("rst_rvalid", {31'd0, bus.iob_rvalid}, 32'h0);
    chk("rst_rdata", bus.iob_rdata, 32'h0);
    chk("ready", {31'd0, bus.iob_ready}, 32'h1);
    rdchk("rst_config", 16'h000, 32'h01080208);
    rdchk("rst_el", 16'h004, 32'h0);
    rdchk("rst_ip", 16'h008, 32'h0);
    rdchk("rst_prio0", 16'h040, 32'h0);
    rdchk("rst_prio7", 16'h05C, 32'h0);
    rdchk("rst_ie1", 16'h110, 32'h0);
    rdchk("rst_th1", 16'h114, 32'h0);
    rdchk("rst_claim0", 16'h108, 32'h0);
    cyc(1);
    chk("rvalid_idle", {31'd0, bus.iob_rvalid}, 32'h0);

    // byte strobes
    wr_s(16'h04C, 32'hFFFF_FFFF, 4'b0010);
    rdchk("strb_none", 16'h04C, 32'h0);
    wr_s(16'h04C, 32'hFFFF_FF05, 4'b0001);
    rdchk("strb_b0", 16'h04C, 32'h5);

    // level source: exact 2-cycle latency, claim, complete with src high
    wr(16'h048, 32'h3);
    wr(16'h100, 32'h04);
    wr(16'h104, 32'h0);
    src[2] = 1'b1;
    cyc(1);
    chk("lvl_irq_c1", {30'd0, irq}, 32'h0);
    cyc(1);
    chk("lvl_irq_c2", {30'd0, irq}, 32'h1);
    rdchk("lvl_ip", 16'h008, 32'h04);
    rdchk("lvl_claim", 16'h108, 32'h3);
    chk("lvl_irq_claimed", {30'd0, irq}, 32'h0);
    rdchk("lvl_ip_claimed", 16'h008, 32'h0);
    wr(16'h108, 32'h3);
    chk("lvl_irq_cmpl0", {30'd0, irq}, 32'h0);
    cyc(1);
    chk("lvl_repend_irq", {30'd0, irq}, 32'h1);
    src[2] = 1'b0;
    cyc(3);
    rdchk("lvl_sticky_ip", 16'h008, 32'h04);
    rdchk("lvl_claim2", 16'h108, 32'h3);
    wr(16'h108, 32'h3);
    cyc(2);
    chk("lvl_idle_irq", {30'd0, irq}, 32'h0);

    // threshold
    wr(16'h040, 32'h2);
    wr(16'h104, 32'h2);
    wr(16'h100, 32'h01);
    src[0] = 1'b1;
    cyc(3);
    chk("th_block_irq", {30'd0, irq}, 32'h0);
    rdchk("th_ip", 16'h008, 32'h01);
    rdchk("th_claim_none", 16'h108, 32'h0);
    wr(16'h104, 32'h1);
    chk("th_pass_irq", {30'd0, irq}, 32'h1);
    src[0] = 1'b0;
    rdchk("th_claim", 16'h108, 32'h1);
    wr(16'h108, 32'h1);
    wr(16'h104, 32'h0);

    // priority and lowest-ID tie break
    wr(16'h044, 32'h5);
    wr(16'h050, 32'h5);
    wr(16'h058, 32'h7);
    wr(16'h100, 32'h52);
    @(negedge clk_i); src = 8'h52;
    @(negedge clk_i); src = 8'h00;
    cyc(2);
    rdchk("pri_ip", 16'h008, 32'h52);
    rdchk("pri_claim_a", 16'h108, 32'h7);
    rdchk("pri_claim_b", 16'h108, 32'h2);
    rdchk("pri_claim_c", 16'h108, 32'h5);
    rdchk("pri_claim_d", 16'h108, 32'h0);
    chk("pri_irq_low", {30'd0, irq}, 32'h0);
    wr(16'h108, 32'h7);
    wr(16'h108, 32'h2);
    wr(16'h108, 32'h5);

    // edge counting with saturation
    wr(16'h100, 32'h01);
    wr(16'h004, 32'h01);
    rdchk("edge_el", 16'h004, 32'h01);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk_i); src[0] = 1'b1;
      @(negedge clk_i); src[0] = 1'b0;
    end
    cyc(2);
    rdchk("edge_ip", 16'h008, 32'h01);
    for (int k = 0; k < 8; k++) begin
      rdchk($sformatf("edge_claim%0d", k), 16'h108, 32'h1);
      wr(16'h108, 32'h1);
    end
    rdchk("edge_claim_sat", 16'h108, 32'h0);
    chk("edge_irq_low", {30'd0, irq}, 32'h0);
    @(negedge clk_i); src[0] = 1'b1;
    @(negedge clk_i); src[0] = 1'b0;
    cyc(1);
    rdchk("edge_ip_again", 16'h008, 32'h01);
    wr(16'h004, 32'h00);
    rdchk("edge_el_clear", 16'h008, 32'h0);

    // multi-target, bad complete IDs ignored
    wr(16'h04C, 32'h5);
    wr(16'h100, 32'h08);
    wr(16'h110, 32'h08);
    src[3] = 1'b1;
    cyc(3);
    chk("mt_irq_both", {30'd0, irq}, 32'h3);
    rdchk("mt_claim_t1", 16'h118, 32'h4);
    chk("mt_irq_none", {30'd0, irq}, 32'h0);
    wr(16'h118, 32'h9);
    wr(16'h118, 32'h0);
    cyc(2);
    chk("mt_bad_cmpl", {30'd0, irq}, 32'h0);
    wr(16'h118, 32'h4);
    cyc(1);
    chk("mt_repend", {30'd0, irq}, 32'h3);
    src[3] = 1'b0;

    // unmapped and read-only addresses
    rdchk("unmapped", 16'h00C, 32'h0);
    wr(16'h008, 32'hFF);
    wr(16'h000, 32'hFFFF_FFFF);
    rdchk("cfg_ro", 16'h000, 32'h01080208);

    // clock enable low freezes state
    cke_i = 1'b0;
    wr(16'h054, 32'h3);
    cke_i = 1'b1;
    rdchk("cke_hold", 16'h054, 32'h0);

    // reset clears everything
    rst_n_i = 1'b0;
    cyc(2);
    rst_n_i = 1'b1;
    chk("rst2_irq", {30'd0, irq}, 32'h0);
    rdchk("rst2_prio3", 16'h04C, 32'h0);
    rdchk("rst2_ie0", 16'h100, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
